// File: rtl/modn_counter_pkg.sv
// Shared constants and combinational helpers for the modulo-N up/down counter.
// Helpers work on 32-bit unsigned values so any counter width up to 31 can use them.
package modn_counter_pkg;

    localparam int unsigned MOD_MIN = 2;

    // A modulus is usable when it leaves at least two states and fits the count width.
    function automatic logic mod_legal(input int unsigned m, input int unsigned width);
        return (m >= MOD_MIN) && (m <= (32'd1 << width));
    endfunction

    function automatic int unsigned next_count(input  int unsigned cnt,
                                               input  int unsigned m,
                                               input  logic        up,
                                               output logic        wrapped);
        int unsigned nxt;
        wrapped = 1'b0;
        if (up) begin
            if (cnt == m - 1) begin
                nxt     = 0;
                wrapped = 1'b1;
            end else begin
                nxt = cnt + 1;
            end
        end else begin
            if (cnt == 0) begin
                nxt     = m - 1;
                wrapped = 1'b1;
            end else begin
                nxt = cnt - 1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              inc,
    output logic [WRAP_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with programmable modulus, preload, registered wrap
// pulse and a saturating tally of wrap events.
module modn_updown_counter
    import modn_counter_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int MOD_DEFAULT = 12,
    parameter int WRAP_W      = 8
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              en,
    input  logic              UpOrDown,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              mod_wr,
    input  logic [WIDTH:0]    mod_val,
    output logic [WIDTH-1:0]  Count,
    output logic [WIDTH:0]    modulus,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              cfg_err
);

    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH:0]   mod_nxt;
    logic             wrap_nxt;
    logic             err_nxt;
    int unsigned      step_val;
    logic             step_wrap;

    // Priority: modulus write, then preload, then the enabled count step.
    always_comb begin
        cnt_nxt   = Count;
        mod_nxt   = modulus;
        wrap_nxt  = 1'b0;
        err_nxt   = 1'b0;
        step_val  = 0;
        step_wrap = 1'b0;
        if (mod_wr) begin
            if (mod_legal(32'(mod_val), WIDTH)) begin
                mod_nxt = mod_val;
                if ({1'b0, Count} >= mod_val)
                    cnt_nxt = '0;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (load) begin
            if ({1'b0, load_val} < modulus)
                cnt_nxt = load_val;
            else
                cnt_nxt = WIDTH'(modulus - 1'b1);
        end else if (en) begin
            step_val = next_count(32'(Count), 32'(modulus), UpOrDown, step_wrap);
            cnt_nxt  = WIDTH'(step_val);
            wrap_nxt = step_wrap;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            Count   <= '0;
            modulus <= (WIDTH+1)'(MOD_DEFAULT);
            wrap    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            Count   <= cnt_nxt;
            modulus <= mod_nxt;
            wrap    <= wrap_nxt;
            cfg_err <= err_nxt;
        end
    end

    // Tally advances on the same edge that raises the wrap pulse.
    sat_counter #(.WRAP_W(WRAP_W)) u_wrap_tally (
        .clk   (Clk),
        .clear (reset),
        .inc   (wrap_nxt),
        .count (wrap_cnt)
    );

endmodule

// File: tb/tb_modn_updown_counter.sv
// Directed bench for modn_updown_counter: default instance plus a narrow-tally instance.
module tb_modn_updown_counter;

    logic       Clk = 1'b0;
    logic       reset, en, UpOrDown, load, mod_wr;
    logic [3:0] load_val;
    logic [4:0] mod_val;
    logic [3:0] Count;
    logic [4:0] modulus;
    logic       wrap, cfg_err;
    logic [7:0] wrap_cnt;

    logic       reset2, en2;
    logic [3:0] Count2;
    logic [4:0] modulus2;
    logic       wrap2, cfg_err2;
    logic [1:0] wrap_cnt2;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    modn_updown_counter #(.WIDTH(4), .MOD_DEFAULT(12), .WRAP_W(8)) dut (
        .Clk(Clk), .reset(reset), .en(en), .UpOrDown(UpOrDown), .load(load),
        .load_val(load_val), .mod_wr(mod_wr), .mod_val(mod_val), .Count(Count),
        .modulus(modulus), .wrap(wrap), .wrap_cnt(wrap_cnt), .cfg_err(cfg_err)
    );

    modn_updown_counter #(.WIDTH(4), .MOD_DEFAULT(2), .WRAP_W(2)) dut2 (
        .Clk(Clk), .reset(reset2), .en(en2), .UpOrDown(1'b1), .load(1'b0),
        .load_val(4'd0), .mod_wr(1'b0), .mod_val(5'd0), .Count(Count2),
        .modulus(modulus2), .wrap(wrap2), .wrap_cnt(wrap_cnt2), .cfg_err(cfg_err2)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1; en = 1; UpOrDown = 1; load = 1; load_val = 4'd5;
        mod_wr = 0; mod_val = 5'd0;
        reset2 = 1; en2 = 0;
        tick();
        check("rst_count", 32'(Count), 0);
        check("rst_modulus", 32'(modulus), 12);
        check("rst_wrap", 32'(wrap), 0);
        check("rst_wrap_cnt", 32'(wrap_cnt), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);

        // Up count through one wrap at modulus 12
        reset = 0; load = 0;
        for (int i = 1; i <= 13; i++) begin
            tick();
            check($sformatf("up_count_%0d", i), 32'(Count), 32'(i % 12));
            check($sformatf("up_wrap_%0d", i), 32'(wrap), (i == 12) ? 32'd1 : 32'd0);
        end
        check("up_wrap_cnt", 32'(wrap_cnt), 1);

        // Down wrap from 0
        load = 1; load_val = 4'd0; en = 0;
        tick();
        check("load0_count", 32'(Count), 0);
        check("load0_wrap", 32'(wrap), 0);
        load = 0; en = 1; UpOrDown = 0;
        tick();
        check("down_wrap_count", 32'(Count), 11);
        check("down_wrap_pulse", 32'(wrap), 1);
        check("down_wrap_cnt", 32'(wrap_cnt), 2);
        tick();
        check("down_step_count", 32'(Count), 10);
        check("down_step_wrap", 32'(wrap), 0);

        // Load with en high: only load applies
        load = 1; load_val = 4'd9; en = 1; UpOrDown = 1;
        tick();
        check("load9_count", 32'(Count), 9);
        check("load9_wrap", 32'(wrap), 0);

        // Shrink modulus below Count
        load = 0; en = 1; mod_wr = 1; mod_val = 5'd5;
        tick();
        check("mod5_modulus", 32'(modulus), 5);
        check("mod5_count", 32'(Count), 0);
        check("mod5_cfg_err", 32'(cfg_err), 0);
        mod_val = 5'd1;
        tick();
        check("mod1_cfg_err", 32'(cfg_err), 1);
        check("mod1_modulus", 32'(modulus), 5);
        check("mod1_count", 32'(Count), 0);
        mod_val = 5'd17;
        tick();
        check("mod17_cfg_err", 32'(cfg_err), 1);
        check("mod17_modulus", 32'(modulus), 5);
        mod_wr = 0; en = 0;
        tick();
        check("err_clears", 32'(cfg_err), 0);

        // Grow modulus above Count: Count holds
        load = 1; load_val = 4'd3;
        tick();
        check("load3_count", 32'(Count), 3);
        load = 0; mod_wr = 1; mod_val = 5'd12;
        tick();
        check("mod12_modulus", 32'(modulus), 12);
        check("mod12_count_hold", 32'(Count), 3);

        // Clamp on out-of-range load; mod_wr overrides load
        mod_wr = 0; load = 1; load_val = 4'd14; en = 1;
        tick();
        check("clamp_count", 32'(Count), 11);
        check("clamp_wrap", 32'(wrap), 0);
        mod_wr = 1; mod_val = 5'd12; load_val = 4'd2;
        tick();
        check("modwr_over_load", 32'(Count), 11);

        // Full binary range at modulus 16
        mod_val = 5'd16; load = 0; en = 0;
        tick();
        check("mod16_modulus", 32'(modulus), 16);
        check("mod16_count_hold", 32'(Count), 11);
        mod_wr = 0; load = 1; load_val = 4'd15;
        tick();
        check("load15_count", 32'(Count), 15);
        load = 0; en = 1; UpOrDown = 1;
        tick();
        check("bin_wrap_count", 32'(Count), 0);
        check("bin_wrap_pulse", 32'(wrap), 1);
        check("bin_wrap_cnt", 32'(wrap_cnt), 3);

        // en toggling each cycle
        en = 1; tick(); check("tog_1", 32'(Count), 1);
        en = 0; tick(); check("tog_2", 32'(Count), 1);
        check("tog_2_wrap", 32'(wrap), 0);
        en = 1; tick(); check("tog_3", 32'(Count), 2);
        en = 0; tick(); check("tog_4", 32'(Count), 2);

        // Reset wins over mod_wr, load and en
        reset = 1; load = 1; load_val = 4'd7; mod_wr = 1; mod_val = 5'd6; en = 1;
        tick();
        check("rst2_count", 32'(Count), 0);
        check("rst2_modulus", 32'(modulus), 12);
        check("rst2_wrap_cnt", 32'(wrap_cnt), 0);
        check("rst2_cfg_err", 32'(cfg_err), 0);
        reset = 0; load = 0; mod_wr = 0; en = 0;

        // Narrow tally saturation at modulus 2
        check("sat_rst_cnt", 32'(wrap_cnt2), 0);
        check("sat_rst_modulus", 32'(modulus2), 2);
        reset2 = 0; en2 = 1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("sat_count_%0d", i), 32'(Count2), 32'(i % 2));
            if (i == 4) check("sat_cnt_after_2", 32'(wrap_cnt2), 2);
            if (i == 6) check("sat_cnt_after_3", 32'(wrap_cnt2), 3);
        end
        check("sat_wrap_pulse", 32'(wrap2), 1);
        check("sat_cnt_final", 32'(wrap_cnt2), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
